// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   RESET_PC_DEF : default reset/first fetch address
//   NOP_INST     : instruction presented in place of a faulting fetch (addi x0,x0,0)
//   fetch_state_e: REQ (may issue a request) / WAIT (one request outstanding)
package if_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/if_out_buf.sv
// One-entry valid/ready holding register between fetch and IF/ID.
// Ports:
//   clk, rst        clock, async active-low reset
//   flush_i         squash the held entry
//   load_i          write a new entry (wins over flush and drain)
//   ld_inst_i/ld_pc_i/ld_fault_i   entry contents to load
//   ready_i         consumer takes the entry this cycle
//   valid_o, inst_o, pc_o, fault_o held entry
module if_out_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [31:0]     ld_inst_i,
    input  logic [XLEN-1:0] ld_pc_i,
    input  logic            ld_fault_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o
);
    logic            valid_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc_q;
    logic            fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else if (load_i) begin
            // A load in the same cycle as a drain is the refill case.
            valid_q <= 1'b1;
            inst_q  <= ld_inst_i;
            pc_q    <= ld_pc_i;
            fault_q <= ld_fault_i;
        end else if (flush_i || ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign fault_o = fault_q;
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight
// to instruction memory and hands {inst, pc, fault} to IF/ID through a
// one-entry buffer. Redirects may arrive in any state; responses belonging
// to a pre-redirect request are dropped.
// Ports:
//   clk, rst                         clock, async active-low reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data/err          fetch response channel
//   redirect_valid/pc                branch/jump redirect from later stages
//   out_valid/ready/inst/pc/fault    IF/ID hand-off
module if_fetch
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault
);
    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            drop_q;    // outstanding response belongs to a squashed request
    logic            halted_q;  // fault delivered; wait for a redirect
    logic            run_q;     // holds off the first request until the cycle after reset

    logic buf_free, req_fire, misalign, capture, buf_load;
    logic [31:0]     ld_inst;
    logic [XLEN-1:0] ld_pc;
    logic            ld_fault;

    assign buf_free       = !out_valid || out_ready;
    assign imem_req_valid = run_q && (state_q == ST_REQ) && !halted_q && buf_free;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign misalign       = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // A redirect in the response cycle makes that response stale too.
    assign capture  = (state_q == ST_WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;
    assign buf_load = capture || misalign;
    assign ld_inst  = (misalign || imem_rsp_err) ? NOP_INST : imem_rsp_data;
    assign ld_pc    = misalign ? redirect_pc : pc_q;
    assign ld_fault = misalign || imem_rsp_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            halted_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                pc_q     <= {redirect_pc[XLEN-1:2], 2'b00};
                halted_q <= misalign;
                unique case (state_q)
                    ST_REQ: if (req_fire) begin
                        // request went out under the old pc
                        state_q <= ST_WAIT;
                        drop_q  <= 1'b1;
                    end
                    ST_WAIT: if (imem_rsp_valid) begin
                        state_q <= ST_REQ;
                        drop_q  <= 1'b0;
                    end else begin
                        drop_q  <= 1'b1;
                    end
                endcase
            end else begin
                unique case (state_q)
                    ST_REQ: if (req_fire) state_q <= ST_WAIT;
                    ST_WAIT: if (imem_rsp_valid) begin
                        state_q <= ST_REQ;
                        drop_q  <= 1'b0;
                        if (!drop_q) begin
                            pc_q <= pc_q + XLEN'(4);
                            if (imem_rsp_err) halted_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    if_out_buf #(.XLEN(XLEN)) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .load_i     (buf_load),
        .ld_inst_i  (ld_inst),
        .ld_pc_i    (ld_pc),
        .ld_fault_i (ld_fault),
        .ready_i    (out_ready),
        .valid_o    (out_valid),
        .inst_o     (out_inst),
        .pc_o       (out_pc),
        .fault_o    (out_fault)
    );
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a transaction-level model (queue of instructions that
// must reach IF/ID, expected next fetch address, halt flag, outstanding
// request tracking) is checked against the DUT every cycle, plus literal
// expectations for the directed scenarios.
module tb_if_fetch;
    import if_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
    logic        redirect_valid, out_valid, out_ready, out_fault;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_inst, out_pc;

    if_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] inst; logic [31:0] pc; logic fault; } item_t;

    item_t       expq[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic        pend = 1'b0, pend_stale = 1'b0, halt_m = 1'b0;
    logic [31:0] pend_addr = '0, exp_fetch = RST_PC, err_addr = 32'h1;
    int          lat = 0, rsp_lat = 0;
    logic        nx_req_ready = 1'b1, nx_out_ready = 1'b1, nx_redir = 1'b0;
    logic [31:0] nx_rpc = '0, arm_pc = '0;
    int          arm = 0;   // 1: redirect on accept, 2: on response, 3: while waiting
    logic [31:0] acc_log[$], cons_pc[$], cons_inst[$];
    int          cons_cyc[$];
    logic [31:0] last_pc = '0, last_inst = '0;
    logic        last_fault = 1'b0, consumed_now = 1'b0, accepted_now = 1'b0;
    int          n0;
    logic        found;

    function automatic logic [31:0] memword(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] first_acc();
        return (acc_log.size() != 0) ? acc_log[0] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    task automatic check_cycle();
        item_t e;
        logic  ok;
        e = '{32'h0, 32'h0, 1'b0};
        n_cmp++;
        if (expq.size() == 0) ok = (out_valid === 1'b0);
        else begin
            e  = expq[0];
            ok = (out_valid === 1'b1) && (out_inst === e.inst) &&
                 (out_pc === e.pc) && (out_fault === e.fault);
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL out@%0d: got v=%b inst=%h pc=%h f=%b, want v=%0d inst=%h pc=%h f=%b",
                     cyc, out_valid, out_inst, out_pc, out_fault, expq.size() != 0,
                     e.inst, e.pc, e.fault);
        end
        n_cmp++;
        if (imem_req_valid !== 1'b0 &&
            (halt_m || pend || (out_valid && !out_ready) || imem_req_addr !== exp_fetch)) begin
            n_bad++;
            $display("FAIL req@%0d: got addr=%h, want none or addr=%h (halt=%b pend=%b)",
                     cyc, imem_req_addr, exp_fetch, halt_m, pend);
        end
    endtask

    task automatic update_model();
        logic redir_now;
        redir_now    = redirect_valid;
        consumed_now = out_valid && out_ready;
        accepted_now = imem_req_valid && imem_req_ready;
        if (consumed_now) begin
            last_pc = out_pc; last_inst = out_inst; last_fault = out_fault;
            cons_pc.push_back(out_pc); cons_inst.push_back(out_inst); cons_cyc.push_back(cyc);
            if (expq.size() != 0) void'(expq.pop_front());
        end
        if (imem_rsp_valid) begin
            pend = 1'b0;
            if (!pend_stale && !redir_now) begin
                expq.push_back('{imem_rsp_err ? NOP : imem_rsp_data, pend_addr, imem_rsp_err});
                exp_fetch = pend_addr + 32'd4;
                if (imem_rsp_err) halt_m = 1'b1;
            end
        end else if (pend && lat > 0) lat--;
        if (redir_now) begin
            if (pend) pend_stale = 1'b1;
            expq.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
            halt_m    = (redirect_pc[1:0] != 2'b00);
            if (halt_m) expq.push_back('{NOP, redirect_pc, 1'b1});
        end
        if (accepted_now) begin
            pend = 1'b1; pend_addr = imem_req_addr; pend_stale = redir_now; lat = rsp_lat;
            acc_log.push_back(imem_req_addr);
        end
        if (redir_now) acc_log.delete();   // log now holds only post-redirect fetches
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk);
            imem_req_ready = nx_req_ready;
            out_ready      = nx_out_ready;
            redirect_valid = nx_redir;
            redirect_pc    = nx_rpc;
            nx_redir       = 1'b0;
            imem_rsp_valid = pend && (lat == 0);
            imem_rsp_data  = memword(pend_addr);
            imem_rsp_err   = pend && (pend_addr == err_addr);
            #1;
            if ((arm == 1 && imem_req_valid && imem_req_ready) ||
                (arm == 2 && imem_rsp_valid) ||
                (arm == 3 && pend && !imem_rsp_valid)) begin
                redirect_valid = 1'b1;
                redirect_pc    = arm_pc;
                arm            = 0;
                #1;
            end
            check_cycle();
            update_model();
            cyc++;
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_out_inst"},  out_inst, 32'h0);
        chk({tag, "_out_pc"},    out_pc, 32'h0);
        chk({tag, "_out_fault"}, 32'(out_fault), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1: streaming fetch, 1-cycle memory, always-ready consumer
        step(8);
        chk("t1_addr0", first_acc(), 32'h8000_0000);
        chk("t1_addr1", acc_log[1], 32'h8000_0004);
        chk("t1_addr2", acc_log[2], 32'h8000_0008);
        chk("t1_pc0",   cons_pc[0], 32'h8000_0000);
        chk("t1_inst0", cons_inst[0], 32'hDA5A_0000);
        chk("t1_inst1", cons_inst[1], 32'hDA5A_0004);
        chk("t1_rate",  32'(cons_cyc[1] - cons_cyc[0]), 32'd2);

        // 2: back-pressure from decode, then release
        nx_out_ready = 1'b0;
        step(6);
        chk("t2_hold_valid", 32'(out_valid), 32'h1);
        chk("t2_hold_noreq", 32'(imem_req_valid), 32'h0);
        nx_out_ready = 1'b1;
        rsp_lat = 3;
        step(1);
        chk("t2_drain_refill", {30'h0, consumed_now, accepted_now}, 32'h3);

        // 3: redirect while a slow response is outstanding
        arm = 3; arm_pc = 32'h8000_0100;
        step(12);
        chk("t3_fired", 32'(arm), 32'h0);
        chk("t3_target", first_acc(), 32'h8000_0100);
        rsp_lat = 0;

        // 4: redirect coincident with a response, then with a request accept
        arm = 2; arm_pc = 32'h8000_0200;
        step(6);
        chk("t4a_fired", 32'(arm), 32'h0);
        chk("t4a_target", first_acc(), 32'h8000_0200);
        arm = 1; arm_pc = 32'h8000_0300;
        step(6);
        chk("t4b_fired", 32'(arm), 32'h0);
        chk("t4b_target", first_acc(), 32'h8000_0300);

        // 5: access fault halts fetch until a redirect
        err_addr = 32'h8000_0008;
        nx_redir = 1'b1; nx_rpc = 32'h8000_0000;
        step(12);
        chk("t5_fault_pc",   last_pc, 32'h8000_0008);
        chk("t5_fault_inst", last_inst, 32'h0000_0013);
        chk("t5_fault_flag", 32'(last_fault), 32'h1);
        n0 = acc_log.size();
        step(5);
        chk("t5_halted", 32'(acc_log.size()), 32'(n0));
        err_addr = 32'h1;
        nx_redir = 1'b1; nx_rpc = 32'h8000_0000;
        step(4);
        chk("t5_resume", first_acc(), 32'h8000_0000);

        // 6: async reset mid-WAIT, then misaligned redirect
        rsp_lat = 5;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            found = pend && (lat > 0);
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL t6_wait: got no outstanding request, want one within 10 cycles");
        end
        rst = 1'b0;
        #1 chk_reset_outputs("t6_rst");
        expq.delete(); pend = 1'b0; pend_stale = 1'b0; halt_m = 1'b0; exp_fetch = RST_PC;
        imem_rsp_valid = 1'b0; rsp_lat = 0; acc_log.delete();
        @(negedge clk);
        rst = 1'b1;
        step(3);
        chk("t6_first_addr", first_acc(), 32'h8000_0000);
        nx_redir = 1'b1; nx_rpc = 32'h8000_0102;
        step(2);
        chk("t6_mis_pc",    last_pc, 32'h8000_0102);
        chk("t6_mis_inst",  last_inst, 32'h0000_0013);
        chk("t6_mis_fault", 32'(last_fault), 32'h1);
        step(4);
        chk("t6_no_fetch", 32'(acc_log.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
